vip_fifo_frame_reader: RTL and testbench
========================================

// Module: vip_fifo_frame_reader
// PURPOSE
//  FIFO-read-side frame sequencer for the VIP core input path: drains pixel words written by the
//  image source (wrreq/full writer) from a normal-mode FIFO (rdreq/data/empty) and emits them as a
//  framed valid/ready stream with sof/eol/eof markers, using latched frame dimensions.
//  Sits between the input FIFO and the first processing stage inside vip_top.
// PARAMETERS
//  DWIDTH   24  pixel word width (RGB888)
//  DIMW     11  width/height field width
// PORTS
//  clock        in   1         system clock; all logic on rising edge
//  reset        in   1         asynchronous, active-high reset
//  width        in   DIMW      pixels per line; sampled on accepted start
//  height       in   DIMW      lines per frame; sampled on accepted start
//  start        in   1         1-cycle request to read one frame
//  fifo_data    in   DWIDTH    FIFO read data, valid the cycle after fifo_rdreq
//  fifo_empty   in   1         FIFO empty flag
//  fifo_rdreq   out  1         FIFO read request (registered)
//  out_data     out  DWIDTH    pixel word
//  out_valid    out  1         out_data/markers valid
//  out_ready    in   1         downstream accept; transfer = out_valid & out_ready
//  out_sof      out  1         first pixel of frame (x=0,y=0)
//  out_eol      out  1         last pixel of a line (x=width-1)
//  out_eof      out  1         last pixel of frame
//  busy         out  1         high while state RUN
//  frame_done   out  1         1-cycle pulse after frame completes
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, counters 0, 2-entry buffer empty, in-flight flag 0.
//  States: IDLE -> RUN on start with width!=0 and height!=0 (latch dims, total=width*height, 22 bit).
//   IDLE -> DONE on start with width==0 or height==0 (no FIFO reads). RUN -> DONE on eof transfer.
//   DONE -> IDLE unconditionally; frame_done=1 only in DONE. start outside IDLE is ignored.
//  Read issue (registered, evaluated each cycle in RUN):
//   fifo_rdreq(next) = RUN & !fifo_empty & req_cnt<total & (occ + inflight - pop) < 2,
//   where occ = buffer entries (0..2), inflight = rdreq issued last cycle, pop = transfer this cycle.
//   Guarantees buffer never overflows and sustains 1 pixel/cycle with out_ready held high.
//   req_cnt increments per issued rdreq; no rdreq issued once req_cnt==total.
//  Capture: cycle after fifo_rdreq, fifo_data written to buffer tail; head drives out_data.
//  Latency: start at cycle N (FIFO non-empty) -> rdreq N+1 -> out_valid N+2 (dims latched N).
//  Output: out_valid = occ!=0; out_data/markers stable while out_valid & !out_ready.
//   Pixel x,y counters advance only on transfer; x wraps width-1 -> 0 with y+1.
//   out_sof = valid & x==0 & y==0; out_eol = valid & x==width-1; out_eof = eol & y==height-1.
//   1x1 frame: sof, eol, eof on the same beat.
//  Simultaneous capture and pop: head advances, new word appended; occ unchanged.
//  fifo_empty mid-frame: reads stall, out_valid drops once buffer drains, resumes in order.
//  Reset mid-frame: immediate return to IDLE; buffered and in-flight words discarded.
//  frame_done cycle: busy=0, out_valid=0; next frame start accepted the cycle after (IDLE).
// TESTING
//  4x2 frame, FIFO preloaded 1..8, out_ready=1 -> 8 consecutive transfers 1..8; sof on 1,
//   eol on 4 and 8, eof on 8; first out_valid 2 cycles after start; frame_done 1 cycle after 8.
//  Same frame, out_ready toggled pseudo-randomly -> data order 1..8 exact, markers intact,
//   fifo_rdreq never issued when occ+inflight-pop>=2, exactly 8 rdreq pulses total.
//  FIFO empty for 5 cycles after pixel 3 -> no rdreq while empty, pixel 4 after refill, no loss.
//  start with width=0 (height=5) -> frame_done next cycle, zero rdreq, out_valid stays 0.
//  1x1 frame -> single beat with sof=eol=eof=1; start pulsed again during RUN -> ignored.
//  reset asserted mid-frame after pixel 2 -> all outputs 0 asynchronously; new 2x2 start reads cleanly.

Source files
------------

// File: rtl/vip_fifo_frame_reader_if.sv
// FIFO read port and framed pixel stream of the VIP frame reader.
// master: the frame reader (drives rdreq and the output stream).
// slave:  the surrounding FIFO and downstream stage.
interface vip_fifo_frame_reader_if #(
  parameter int unsigned DWIDTH = 24
) ();
  logic              fifo_rdreq;
  logic [DWIDTH-1:0] fifo_data;
  logic              fifo_empty;
  logic [DWIDTH-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic              out_sof;
  logic              out_eol;
  logic              out_eof;

  modport master (
    output fifo_rdreq,
    input  fifo_data,
    input  fifo_empty,
    output out_data,
    output out_valid,
    input  out_ready,
    output out_sof,
    output out_eol,
    output out_eof
  );

  modport slave (
    input  fifo_rdreq,
    output fifo_data,
    output fifo_empty,
    input  out_data,
    input  out_valid,
    output out_ready,
    input  out_sof,
    input  out_eol,
    input  out_eof
  );
endinterface

// File: rtl/vip_fifo_frame_reader.sv
// Frame reader: drains one frame of pixel words from a normal-mode FIFO into a
// 2-entry skid buffer and emits them as a valid/ready stream with sof/eol/eof.
module vip_fifo_frame_reader #(
  parameter int unsigned DWIDTH = 24,
  parameter int unsigned DIMW   = 11
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [DIMW-1:0]           width,
  input  logic [DIMW-1:0]           height,
  input  logic                      start,
  output logic                      busy,
  output logic                      frame_done,
  vip_fifo_frame_reader_if.master   bus
);

  localparam int unsigned TotW = 2 * DIMW;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e            state_q, state_d;
  logic [DIMW-1:0]   w_q, w_d, h_q, h_d;
  logic [DIMW-1:0]   x_q, x_d, y_q, y_d;
  logic [TotW-1:0]   total_q, total_d;
  logic [TotW-1:0]   req_cnt_q, req_cnt_d;
  logic              rdreq_q, rdreq_d;
  logic [DWIDTH-1:0] buf_q [2];
  logic              head_q;
  logic [1:0]        occ_q, occ_d;

  logic              valid;
  logic              pop;
  logic              eol;
  logic              eof;
  logic              tail;
  logic [2:0]        claim;

  assign valid = (occ_q != 2'd0);
  assign pop   = valid & bus.out_ready;
  assign eol   = valid & (x_q == w_q - DIMW'(1));
  assign eof   = eol & (y_q == h_q - DIMW'(1));
  // A capture only ever lands while at most one entry is held.
  assign tail  = head_q ^ occ_q[0];
  // Words held or already requested once this cycle's pop has left.
  assign claim = 3'(occ_q) + 3'(rdreq_q) - 3'(pop);
  assign occ_d = occ_q + 2'(rdreq_q) - 2'(pop);

  assign busy           = (state_q == StRun);
  assign frame_done     = (state_q == StDone);
  assign bus.fifo_rdreq = rdreq_q;
  assign bus.out_valid  = valid;
  assign bus.out_data   = buf_q[head_q];
  assign bus.out_sof    = valid & (x_q == '0) & (y_q == '0);
  assign bus.out_eol    = eol;
  assign bus.out_eof    = eof;

  // Next-state, dimension latch, pixel position and read issue.
  always_comb begin
    state_d   = state_q;
    w_d       = w_q;
    h_d       = h_q;
    x_d       = x_q;
    y_d       = y_q;
    total_d   = total_q;
    req_cnt_d = req_cnt_q;
    rdreq_d   = 1'b0;
    case (state_q)
      StIdle: begin
        if (start) begin
          if (width != '0 && height != '0) begin
            state_d = StRun;
            w_d     = width;
            h_d     = height;
            x_d     = '0;
            y_d     = '0;
            total_d = TotW'(width) * TotW'(height);
          end else begin
            state_d = StDone;
          end
        end
      end
      StRun: begin
        if (pop) begin
          if (eol) begin
            x_d = '0;
            y_d = y_q + DIMW'(1);
          end else begin
            x_d = x_q + DIMW'(1);
          end
          if (eof) state_d = StDone;
        end
      end
      StDone: begin
        state_d   = StIdle;
        req_cnt_d = '0;
      end
      default: state_d = StIdle;
    endcase
    // Issuing from the accepting cycle gives rdreq one cycle after start.
    rdreq_d = (state_d == StRun) && !bus.fifo_empty && (req_cnt_q < total_d) &&
              (claim < 3'd2);
    if (rdreq_d) req_cnt_d = req_cnt_q + TotW'(1);
  end

  // Control state and counters.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      w_q       <= '0;
      h_q       <= '0;
      x_q       <= '0;
      y_q       <= '0;
      total_q   <= '0;
      req_cnt_q <= '0;
      rdreq_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      w_q       <= w_d;
      h_q       <= h_d;
      x_q       <= x_d;
      y_q       <= y_d;
      total_q   <= total_d;
      req_cnt_q <= req_cnt_d;
      rdreq_q   <= rdreq_d;
    end
  end

  // Skid buffer: capture the word read last cycle at the tail, pop from the head.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      buf_q[0] <= '0;
      buf_q[1] <= '0;
      head_q   <= 1'b0;
      occ_q    <= 2'd0;
    end else begin
      if (rdreq_q) buf_q[tail] <= bus.fifo_data;
      if (pop) head_q <= ~head_q;
      occ_q <= occ_d;
    end
  end

endmodule

// File: tb/tb_vip_fifo_frame_reader.sv
// Bench for vip_fifo_frame_reader: queue-based FIFO model and a per-pixel
// reference derived from the frame geometry (pixel k of a WxH frame).
module tb_vip_fifo_frame_reader;
  localparam int unsigned DW   = 24;
  localparam int unsigned DIMW = 11;

  logic            clock = 1'b0;
  logic            reset;
  logic [DIMW-1:0] width, height;
  logic            start;
  logic            busy, frame_done;

  vip_fifo_frame_reader_if #(.DWIDTH(DW)) bus ();

  vip_fifo_frame_reader #(.DWIDTH(DW), .DIMW(DIMW)) dut (
    .clock      (clock),
    .reset      (reset),
    .width      (width),
    .height     (height),
    .start      (start),
    .busy       (busy),
    .frame_done (frame_done),
    .bus        (bus.master)
  );

  always #5 clock = ~clock;

  int n_assert, n_fail;
  logic [DW-1:0] fifo_q[$];
  logic [DW-1:0] exp_q[$];
  int cyc, start_cyc, first_rd, first_valid, first_xfer, last_xfer;
  int eof_cyc, done_cyc, done_cnt, rd_cnt, xfer_cnt, max_out, fw, fh;
  bit empty_prev, held, pop_pending;
  logic [DW+2:0] held_val;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // FIFO model: head word always presented; empty once every stored word has a
  // read already issued against it.
  task automatic fifo_refresh();
    bus.fifo_data  = (fifo_q.size() != 0) ? fifo_q[0] : '0;
    bus.fifo_empty = (fifo_q.size() <= int'(bus.fifo_rdreq));
  endtask

  task automatic push(input logic [DW-1:0] w);
    fifo_q.push_back(w);
    exp_q.push_back(w);
  endtask

  // Observe the current cycle just before its rising edge.
  task automatic sample();
    logic [2:0] mk, emk;
    int k;
    if (empty_prev) chk("rdreq_while_empty", 64'(bus.fifo_rdreq), 64'(0));
    if (bus.fifo_rdreq) begin
      rd_cnt++;
      if (first_rd < 0) first_rd = cyc;
    end
    if (rd_cnt - xfer_cnt > max_out) max_out = rd_cnt - xfer_cnt;
    mk = {bus.out_sof, bus.out_eol, bus.out_eof};
    if (bus.out_valid && first_valid < 0) first_valid = cyc;
    if (!bus.out_valid) chk("markers_without_valid", 64'(mk), 64'(0));
    if (held && bus.out_valid) chk("stall_hold", 64'({bus.out_data, mk}), 64'(held_val));
    held     = bus.out_valid && !bus.out_ready;
    held_val = {bus.out_data, mk};
    if (bus.out_valid && bus.out_ready) begin
      k = xfer_cnt;
      if (fw != 0) emk = {k == 0, (k % fw) == fw - 1, k == fw * fh - 1};
      else emk = 3'b111;
      chk("model_has_pixel", 64'(exp_q.size() != 0), 64'(1));
      if (exp_q.size() != 0) chk("pixel_data", 64'(bus.out_data), 64'(exp_q.pop_front()));
      chk("pixel_markers", 64'(mk), 64'(emk));
      if (k == fw * fh - 1) eof_cyc = cyc;
      if (first_xfer < 0) first_xfer = cyc;
      last_xfer = cyc;
      xfer_cnt++;
    end
    if (frame_done) begin
      done_cnt++;
      if (done_cyc < 0) done_cyc = cyc;
      chk("done_busy_valid_low", 64'({busy, bus.out_valid}), 64'(0));
    end
    empty_prev  = bus.fifo_empty;
    pop_pending = bus.fifo_rdreq;
  endtask

  task automatic tick();
    sample();
    @(posedge clock);
    if (pop_pending && fifo_q.size() != 0) void'(fifo_q.pop_front());
    @(negedge clock);
    cyc++;
    fifo_refresh();
  endtask

  task automatic do_start(input int w, input int h);
    fw = w; fh = h;
    rd_cnt = 0; xfer_cnt = 0; max_out = 0; done_cnt = 0;
    first_rd = -1; first_valid = -1; first_xfer = -1; last_xfer = -1;
    eof_cyc = -1; done_cyc = -1;
    width = DIMW'(w); height = DIMW'(h); start = 1'b1;
    start_cyc = cyc;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input bit rand_ready);
    int n = 0;
    while (done_cyc < 0 && n < budget) begin
      if (rand_ready) bus.out_ready = 1'($urandom_range(0, 1));
      tick();
      n++;
    end
    chk("frame_done_seen", 64'(done_cyc >= 0), 64'(1));
    bus.out_ready = 1'b1;
  endtask

  task automatic wait_xfers(input int target, input int budget);
    int n = 0;
    while (xfer_cnt < target && n < budget) begin
      tick();
      n++;
    end
    chk("xfer_target_reached", 64'(xfer_cnt), 64'(target));
  endtask

  task automatic clear_fifo();
    fifo_q.delete();
    exp_q.delete();
    fifo_refresh();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_assert = 0; n_fail = 0; cyc = 0;
    reset = 1'b1; start = 1'b0; width = '0; height = '0;
    bus.out_ready = 1'b0; bus.fifo_data = '0; bus.fifo_empty = 1'b1;
    held = 0; empty_prev = 0; pop_pending = 0; fw = 1; fh = 1; done_cyc = -1;
    rd_cnt = 0; xfer_cnt = 0; max_out = 0; done_cnt = 0;
    first_rd = -1; first_valid = -1; first_xfer = -1; last_xfer = -1; eof_cyc = -1;

    @(negedge clock);
    chk("reset_state", 64'({busy, frame_done, bus.fifo_rdreq, bus.out_valid, bus.out_sof,
                           bus.out_eol, bus.out_eof, bus.out_data}), 64'(0));
    @(negedge clock);
    reset = 1'b0;
    fifo_refresh();
    tick(); tick();

    // 4x2 frame, FIFO preloaded 1..8, downstream always ready.
    for (int i = 1; i <= 8; i++) push(DW'(i));
    fifo_refresh();
    bus.out_ready = 1'b1;
    do_start(4, 2);
    wait_done(40, 0);
    tick(); tick();
    chk("t1_rdreq_latency", 64'(first_rd - start_cyc), 64'(1));
    chk("t1_valid_latency", 64'(first_valid - start_cyc), 64'(2));
    chk("t1_xfer_count", 64'(xfer_cnt), 64'(8));
    chk("t1_rdreq_count", 64'(rd_cnt), 64'(8));
    chk("t1_back_to_back", 64'(last_xfer - first_xfer), 64'(7));
    chk("t1_done_after_eof", 64'(done_cyc - eof_cyc), 64'(1));
    chk("t1_done_pulses", 64'(done_cnt), 64'(1));

    // Same frame, random words, random backpressure.
    for (int i = 0; i < 8; i++) push(DW'($urandom));
    fifo_refresh();
    bus.out_ready = 1'($urandom_range(0, 1));
    do_start(4, 2);
    wait_done(300, 1);
    tick(); tick();
    chk("t2_xfer_count", 64'(xfer_cnt), 64'(8));
    chk("t2_rdreq_count", 64'(rd_cnt), 64'(8));
    chk("t2_outstanding_le2", 64'(max_out <= 2), 64'(1));
    chk("t2_done_pulses", 64'(done_cnt), 64'(1));

    // FIFO runs dry after pixel 3 for 5 cycles, then refills.
    for (int i = 1; i <= 3; i++) push(DW'(24'h100 + i));
    fifo_refresh();
    do_start(4, 2);
    wait_xfers(3, 40);
    chk("t3_reads_before_gap", 64'(rd_cnt), 64'(3));
    for (int i = 0; i < 5; i++) tick();
    chk("t3_reads_during_gap", 64'(rd_cnt), 64'(3));
    chk("t3_valid_drained", 64'(bus.out_valid), 64'(0));
    for (int i = 4; i <= 8; i++) push(DW'(24'h100 + i));
    fifo_refresh();
    wait_done(60, 0);
    chk("t3_xfer_count", 64'(xfer_cnt), 64'(8));
    chk("t3_rdreq_count", 64'(rd_cnt), 64'(8));

    // Zero-width frame with words waiting in the FIFO: nothing read.
    push(DW'(24'hAAAAAA)); push(DW'(24'h555555));
    fifo_refresh();
    do_start(0, 5);
    for (int i = 0; i < 4; i++) tick();
    chk("t4_done_latency", 64'(done_cyc - start_cyc), 64'(1));
    chk("t4_no_rdreq", 64'(rd_cnt), 64'(0));
    chk("t4_no_valid", 64'(first_valid < 0), 64'(1));
    chk("t4_done_pulses", 64'(done_cnt), 64'(1));
    clear_fifo();

    // 1x1 frame; a second start while running must be ignored.
    push(DW'(24'hC0FFEE)); push(DW'(24'hBADBAD));
    fifo_refresh();
    do_start(1, 1);
    width = DIMW'(3); height = DIMW'(3); start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(20, 0);
    for (int i = 0; i < 4; i++) tick();
    chk("t5_xfer_count", 64'(xfer_cnt), 64'(1));
    chk("t5_rdreq_count", 64'(rd_cnt), 64'(1));
    chk("t5_done_pulses", 64'(done_cnt), 64'(1));
    chk("t5_idle_after", 64'({busy, frame_done}), 64'(0));
    clear_fifo();

    // Reset mid-frame after pixel 2, then a clean 2x2 frame.
    for (int i = 1; i <= 8; i++) push(DW'(24'h200 + i));
    fifo_refresh();
    do_start(4, 2);
    wait_xfers(2, 40);
    reset = 1'b1;
    #1;
    chk("t6_async_reset_outputs", 64'({busy, frame_done, bus.fifo_rdreq, bus.out_valid,
                                      bus.out_sof, bus.out_eol, bus.out_eof, bus.out_data}),
        64'(0));
    @(negedge clock);
    reset = 1'b0;
    held = 0; empty_prev = 0;
    clear_fifo();
    for (int i = 1; i <= 4; i++) push(DW'(24'h300 + i));
    fifo_refresh();
    tick();
    do_start(2, 2);
    wait_done(40, 0);
    tick();
    chk("t6_xfer_count", 64'(xfer_cnt), 64'(4));
    chk("t6_rdreq_count", 64'(rd_cnt), 64'(4));
    chk("t6_valid_latency", 64'(first_valid - start_cyc), 64'(2));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
